// File: rtl/pll_reset_sequencer.sv
// Purpose: qualifies a raw PLL lock, then releases per-channel resets in a staggered order.
// Latency: first reset release 2 + LOCK_STABLE_CYCLES edges after pll_locked is first sampled high.
// Backpressure: none; lock loss immediately re-asserts every reset. Optional loss_count via PLL_RESET_SEQ_LOSS_COUNTER_EN.
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int NUM_CHANNELS       = 2,
    parameter int STAGGER_CYCLES     = 16,
    parameter int LOSS_CNT_WIDTH     = 8
) (
    input  logic                      clock_in,
    input  logic                      reset,
    input  logic                      pll_locked,
    input  logic                      clear_sticky,
    output logic [NUM_CHANNELS-1:0]   chan_reset,
    output logic                      ready,
    output logic                      lock_lost_sticky
`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
    ,
    output logic [LOSS_CNT_WIDTH-1:0] loss_count
`endif
);

    localparam int CNT_W = $clog2(LOCK_STABLE_CYCLES);
    localparam int STG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STG_W-1:0] STAGGER_LAST = STG_W'(STAGGER_CYCLES - 1);

    generate
        if (LOCK_STABLE_CYCLES < 2 || LOCK_STABLE_CYCLES > 65535) begin : g_bad_lsc
            $error("LOCK_STABLE_CYCLES out of range");
        end
        if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_bad_nch
            $error("NUM_CHANNELS out of range");
        end
        if (STAGGER_CYCLES < 1 || STAGGER_CYCLES > 255) begin : g_bad_stg
            $error("STAGGER_CYCLES out of range");
        end
        if (LOSS_CNT_WIDTH < 1) begin : g_bad_lcw
            $error("LOSS_CNT_WIDTH must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_sync1;
    logic                    r_sync2;
    logic [CNT_W-1:0]        r_stable_cnt;
    logic [STG_W-1:0]        r_stagger_cnt;
    logic [NUM_CHANNELS-1:0] r_chan_reset;
    logic                    r_ready;
    logic                    r_sticky;
    logic                    w_lock_s;
    logic                    w_loss_evt;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s   = r_sync2;
    // A loss only counts once the outputs have actually been handed to the downstream logic.
    assign w_loss_evt = (r_state == RUN) && !w_lock_s;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state       <= WAIT_LOCK;
            r_stable_cnt  <= '0;
            r_stagger_cnt <= '0;
            r_chan_reset  <= '1;
            r_ready       <= 1'b0;
            r_sticky      <= 1'b0;
        end else begin
            if (w_loss_evt) begin
                r_sticky <= 1'b1;
            end else if (clear_sticky) begin
                r_sticky <= 1'b0;
            end

            case (r_state)
                WAIT_LOCK: begin
                    r_chan_reset  <= '1;
                    r_ready       <= 1'b0;
                    r_stable_cnt  <= '0;
                    r_stagger_cnt <= '0;
                    if (w_lock_s) begin
                        r_state <= QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (!w_lock_s) begin
                        r_state      <= WAIT_LOCK;
                        r_stable_cnt <= '0;
                    end else if (r_stable_cnt == STABLE_LAST) begin
                        r_state       <= RELEASE;
                        r_stable_cnt  <= '0;
                        r_stagger_cnt <= '0;
                        r_chan_reset  <= r_chan_reset << 1;
                    end else begin
                        r_stable_cnt <= r_stable_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    // Released bits are zero-filled from the bottom, so all-zero means every channel is out.
                    if (!w_lock_s) begin
                        r_state       <= WAIT_LOCK;
                        r_chan_reset  <= '1;
                        r_ready       <= 1'b0;
                        r_stagger_cnt <= '0;
                    end else if (r_chan_reset == '0) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else if (r_stagger_cnt == STAGGER_LAST) begin
                        r_chan_reset  <= r_chan_reset << 1;
                        r_stagger_cnt <= '0;
                    end else begin
                        r_stagger_cnt <= r_stagger_cnt + STG_W'(1);
                    end
                end
                RUN: begin
                    if (!w_lock_s) begin
                        r_state       <= WAIT_LOCK;
                        r_chan_reset  <= '1;
                        r_ready       <= 1'b0;
                        r_stagger_cnt <= '0;
                    end else begin
                        r_chan_reset <= '0;
                        r_ready      <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= WAIT_LOCK;
                    r_chan_reset <= '1;
                    r_ready      <= 1'b0;
                end
            endcase
        end
    end

    assign chan_reset       = r_chan_reset;
    assign ready            = r_ready;
    assign lock_lost_sticky = r_sticky;

`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
    logic [LOSS_CNT_WIDTH-1:0] r_loss_count;

    // A clear coincident with a loss restarts the tally at one rather than zero.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_loss_count <= '0;
        end else if (w_loss_evt) begin
            if (clear_sticky) begin
                r_loss_count <= LOSS_CNT_WIDTH'(1);
            end else if (r_loss_count != '1) begin
                r_loss_count <= r_loss_count + LOSS_CNT_WIDTH'(1);
            end
        end else if (clear_sticky) begin
            r_loss_count <= '0;
        end
    end

    assign loss_count = r_loss_count;
`else
    // Loss events are reflected only in lock_lost_sticky in this build.
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a default instance (A) and a 4-channel fast instance (B),
// both compared every cycle against a lock-streak model, plus directed timing points.
module tb_pll_reset_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic lock_in [2];
    logic clr_in  [2];

    logic [1:0] a_chan;
    logic       a_rdy;
    logic       a_sticky;
    logic [3:0] b_chan;
    logic       b_rdy;
    logic       b_sticky;
`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
    logic [7:0] a_cnt;
    logic [1:0] b_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: two-edge lock visibility delay, consecutive-lock streak, sticky and count.
    bit m_h1 [2];
    bit m_h2 [2];
    bit m_rdy [2];
    bit m_sticky [2];
    int m_n [2];
    int m_cnt [2];

    always #5 clk = ~clk;

    pll_reset_sequencer dut_a (
        .clock_in         (clk),
        .reset            (rst),
        .pll_locked       (lock_in[0]),
        .clear_sticky     (clr_in[0]),
        .chan_reset       (a_chan),
        .ready            (a_rdy),
        .lock_lost_sticky (a_sticky)
`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
        ,
        .loss_count       (a_cnt)
`endif
    );

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (2),
        .NUM_CHANNELS       (4),
        .STAGGER_CYCLES     (1),
        .LOSS_CNT_WIDTH     (2)
    ) dut_b (
        .clock_in         (clk),
        .reset            (rst),
        .pll_locked       (lock_in[1]),
        .clear_sticky     (clr_in[1]),
        .chan_reset       (b_chan),
        .ready            (b_rdy),
        .lock_lost_sticky (b_sticky)
`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
        ,
        .loss_count       (b_cnt)
`endif
    );

    function automatic int p_lsc(input int i);
        return (i == 0) ? 1024 : 2;
    endfunction
    function automatic int p_nch(input int i);
        return (i == 0) ? 2 : 4;
    endfunction
    function automatic int p_stg(input int i);
        return (i == 0) ? 16 : 1;
    endfunction
    function automatic int p_cmax(input int i);
        return (i == 0) ? 255 : 3;
    endfunction

    // Channels released after a streak of n lock-visible edges.
    function automatic int rel_count(input int i);
        int r;
        if (m_n[i] <= p_lsc(i)) return 0;
        r = 1 + (m_n[i] - p_lsc(i) - 1) / p_stg(i);
        return (r > p_nch(i)) ? p_nch(i) : r;
    endfunction

    function automatic int exp_chan(input int i);
        return ((1 << p_nch(i)) - 1) & ~((1 << rel_count(i)) - 1);
    endfunction

    function automatic bit exp_rdy(input int i);
        return m_n[i] >= p_lsc(i) + (p_nch(i) - 1) * p_stg(i) + 2;
    endfunction

    task automatic model_reset(input int i);
        m_h1[i] = 1'b0; m_h2[i] = 1'b0; m_n[i] = 0;
        m_rdy[i] = 1'b0; m_sticky[i] = 1'b0; m_cnt[i] = 0;
    endtask

    task automatic model_edge(input int i);
        bit seen;
        bit loss;
        if (rst) begin
            model_reset(i);
            return;
        end
        seen    = m_h2[i];
        m_h2[i] = m_h1[i];
        m_h1[i] = lock_in[i];
        loss    = 1'b0;
        if (!seen) begin
            loss   = m_rdy[i];
            m_n[i] = 0;
        end else if (m_n[i] < 1000000) begin
            m_n[i]++;
        end
        if (loss) m_sticky[i] = 1'b1;
        else if (clr_in[i]) m_sticky[i] = 1'b0;
        if (loss) m_cnt[i] = clr_in[i] ? 1 : ((m_cnt[i] < p_cmax(i)) ? m_cnt[i] + 1 : m_cnt[i]);
        else if (clr_in[i]) m_cnt[i] = 0;
        m_rdy[i] = exp_rdy(i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_edge(0);
        model_edge(1);
        chk("A.chan_reset", 32'(a_chan), 32'(exp_chan(0)));
        chk("A.ready", 32'(a_rdy), 32'(m_rdy[0]));
        chk("A.sticky", 32'(a_sticky), 32'(m_sticky[0]));
        chk("B.chan_reset", 32'(b_chan), 32'(exp_chan(1)));
        chk("B.ready", 32'(b_rdy), 32'(m_rdy[1]));
        chk("B.sticky", 32'(b_sticky), 32'(m_sticky[1]));
`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
        chk("A.loss_count", 32'(a_cnt), 32'(m_cnt[0]));
        chk("B.loss_count", 32'(b_cnt), 32'(m_cnt[1]));
`endif
    endtask

    initial begin
        int fall0, fall1, rise, s, g;
        logic [3:0] b_seq [6];
        logic       b_rseq [6];

        rst = 1'b1;
        lock_in[0] = 1'b0; lock_in[1] = 1'b0;
        clr_in[0]  = 1'b0; clr_in[1]  = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (3) step();
        rst = 1'b0;
        cyc = 0;

        // Lock first sampled high on edge 10 for both instances.
        repeat (9) step();
        lock_in[0] = 1'b1;
        lock_in[1] = 1'b1;
        fall0 = -1; fall1 = -1; rise = -1;
        while (cyc < 1060) begin
            step();
            if (fall0 < 0 && a_chan[0] == 1'b0) fall0 = cyc;
            if (fall1 < 0 && a_chan[1] == 1'b0) fall1 = cyc;
            if (rise < 0 && a_rdy) rise = cyc;
            if (cyc >= 13 && cyc <= 18) begin
                b_seq[cyc-13]  = b_chan;
                b_rseq[cyc-13] = b_rdy;
            end
        end
        chk("A.chan0_fall_cycle", fall0, 1036);
        chk("A.chan1_fall_cycle", fall1, 1052);
        chk("A.ready_rise_cycle", rise, 1053);
        chk("B.seq0", 32'(b_seq[0]), 32'h0F);
        chk("B.seq1", 32'(b_seq[1]), 32'h0E);
        chk("B.seq2", 32'(b_seq[2]), 32'h0C);
        chk("B.seq3", 32'(b_seq[3]), 32'h08);
        chk("B.seq4", 32'(b_seq[4]), 32'h00);
        chk("B.ready_seq4", 32'(b_rseq[4]), 32'h0);
        chk("B.ready_seq5", 32'(b_rseq[5]), 32'h1);

        // Three-cycle drop while A is in RUN.
        lock_in[0] = 1'b0;
        repeat (3) step();
        chk("A.loss_chan", 32'(a_chan), 32'h3);
        chk("A.loss_ready", 32'(a_rdy), 32'h0);
        chk("A.loss_sticky", 32'(a_sticky), 32'h1);
`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
        chk("A.loss_count1", 32'(a_cnt), 32'h1);
`endif
        lock_in[0] = 1'b1;
        s = cyc + 1;
        fall0 = -1; rise = -1;
        repeat (1060) begin
            step();
            if (fall0 < 0 && a_chan[0] == 1'b0) fall0 = cyc;
            if (rise < 0 && a_rdy) rise = cyc;
        end
        chk("A.relock_fall", fall0 - s, 1026);
        chk("A.relock_ready", rise - s, 1043);
        clr_in[0] = 1'b1;
        step();
        clr_in[0] = 1'b0;
        chk("A.cleared_sticky", 32'(a_sticky), 32'h0);

        // Five losses from RUN on B, then clear, then clear coincident with loss.
        for (int k = 0; k < 5; k++) begin
            lock_in[1] = 1'b0;
            repeat (3) step();
            lock_in[1] = 1'b1;
            repeat (10) step();
        end
        chk("B.sticky_after5", 32'(b_sticky), 32'h1);
`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
        chk("B.count_sat", 32'(b_cnt), 32'h3);
`endif
        clr_in[1] = 1'b1;
        step();
        clr_in[1] = 1'b0;
        chk("B.sticky_clr", 32'(b_sticky), 32'h0);
`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
        chk("B.count_clr", 32'(b_cnt), 32'h0);
`endif
        lock_in[1] = 1'b0;
        repeat (2) step();
        clr_in[1] = 1'b1;
        step();
        clr_in[1] = 1'b0;
        chk("B.sticky_set_wins", 32'(b_sticky), 32'h1);
`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
        chk("B.count_set_wins", 32'(b_cnt), 32'h1);
`endif
        lock_in[1] = 1'b1;

        // One-cycle glitch part-way through A's qualification.
        lock_in[0] = 1'b0;
        repeat (3) step();
        lock_in[0] = 1'b1;
        repeat (502) step();
        lock_in[0] = 1'b0;
        step();
        lock_in[0] = 1'b1;
        g = cyc + 1;
        fall0 = -1;
        while (fall0 < 0 && cyc < g + 1100) begin
            step();
            if (a_chan[0] == 1'b0) fall0 = cyc;
        end
        chk("A.glitch_release", fall0 - g, 1026);

        // Asynchronous reset while A is part-way through RELEASE.
        repeat (3) step();
        #2;
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        chk("A.async_chan", 32'(a_chan), 32'h3);
        chk("A.async_ready", 32'(a_rdy), 32'h0);
        chk("B.async_chan", 32'(b_chan), 32'hF);
        repeat (2) step();
        rst = 1'b0;
        cyc = 0;

        // Random lock toggling and clear pulses, checked every cycle by the model.
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 49) == 0) lock_in[0] = ~lock_in[0];
            if ($urandom_range(0, 7) == 0)  lock_in[1] = ~lock_in[1];
            clr_in[0] = ($urandom_range(0, 15) == 0);
            clr_in[1] = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronised-lock cycles required before the lock is treated as valid (legal range 2..65535).
REQ-002 Parameter NUM_CHANNELS, default 2: number of downstream reset channels (legal range 1..8).
REQ-003 Parameter STAGGER_CYCLES, default 16: gap between successive channel reset releases (legal range 1..255).
REQ-004 Parameter LOSS_CNT_WIDTH, default 8: width of the lock-loss event counter.
REQ-005 clock_in  input  1: free-running reference clock that also feeds the PLL; all logic is clocked on its rising edge.
REQ-006 reset  input  1: asynchronous, active-high reset.
REQ-007 pll_locked  input  1: raw PLL lock indication, asynchronous to clock_in.
REQ-008 clear_sticky  input  1: synchronous single-cycle pulse that clears lock_lost_sticky and loss_count.
REQ-009 chan_reset  output  NUM_CHANNELS: per-channel active-high reset; bit 0 is released first.
REQ-010 ready  output  1: high only when every channel is out of reset and the lock is valid.
REQ-011 lock_lost_sticky  output  1: set on any loss of lock after the block has reached RUN.
REQ-012 loss_count  output  LOSS_CNT_WIDTH: number of lock-loss events (present only with the macro).

Function
REQ-013 pll_locked shall pass through a two-flop synchroniser; every later reference to lock means the synchronised value, lock_s.
REQ-014 FSM states: WAIT_LOCK, QUALIFY, RELEASE, RUN.
REQ-015 WAIT_LOCK: all chan_reset bits high, ready low, stable counter held at 0; go to QUALIFY on the first cycle lock_s=1.
REQ-016 QUALIFY: the stable counter increments on each cycle with lock_s=1; any cycle with lock_s=0 returns to WAIT_LOCK and zeroes the counter; on reaching LOCK_STABLE_CYCLES-1, go to RELEASE.
REQ-017 RELEASE: chan_reset[0] deasserts on the first RELEASE cycle; chan_reset[k] deasserts STAGGER_CYCLES cycles after chan_reset[k-1]; a released bit stays low while in RELEASE.
REQ-018 RELEASE exits to RUN on the cycle after the last channel is released; ready goes high on the first RUN cycle.
REQ-019 RUN: all chan_reset bits low and ready high for as long as lock_s=1.
REQ-020 lock_s=0 in RELEASE or RUN: on the next clock edge, all chan_reset bits are reasserted, ready goes low, the stagger counter is cleared, and the FSM enters WAIT_LOCK.
REQ-021 Lock loss taken from RUN shall set lock_lost_sticky; lock loss in RELEASE shall not set it.
REQ-022 clear_sticky clears the sticky flag in the same cycle as a new loss event: set wins.
REQ-023 Latency from the pll_locked rising edge to the chan_reset[0] release is exactly 2 + LOCK_STABLE_CYCLES cycles, counted from the first edge that samples pll_locked high.
REQ-024 With NUM_CHANNELS=1, RELEASE lasts one cycle and STAGGER_CYCLES has no effect.

Reset
REQ-025 While reset is high, the FSM shall be in WAIT_LOCK, the synchroniser shall hold 0, chan_reset shall be all ones, ready shall be 0, lock_lost_sticky shall be 0, loss_count shall be 0, and all counters shall be 0.
REQ-026 Reset asserted mid-sequence shall take effect immediately without a clock; after deassertion, the sequence restarts from WAIT_LOCK.

Configuration
REQ-027 Macro PLL_RESET_SEQ_LOSS_COUNTER_EN: when defined, loss_count increments on every loss event counted in REQ-021, saturates at all ones without wrapping, and is cleared by clear_sticky; a clear_sticky coincident with a loss event yields a value of 1.
REQ-028 When PLL_RESET_SEQ_LOSS_COUNTER_EN is undefined, the port loss_count shall not exist and no counter logic shall be present; all other behaviour is unchanged.

Verification
REQ-029 Defaults, pll_locked rises at cycle 10 and stays high -> chan_reset[0] falls at cycle 1036, chan_reset[1] falls at cycle 1052, ready rises at cycle 1053.
REQ-030 pll_locked glitches low for 1 cycle at QUALIFY count 500 -> counter restarts; no chan_reset bit is released before 1026 cycles after the glitch ends.
REQ-031 In RUN, drop pll_locked for 3 cycles -> chan_reset is all ones and ready is 0 by the 3rd edge; lock_lost_sticky=1; loss_count=1; after relock, the full requalify-and-release sequence is repeated.
REQ-032 With LOSS_CNT_WIDTH=2, force 5 losses from RUN -> loss_count reads 3; a clear_sticky pulse -> 0; clear coincident with a loss -> lock_lost_sticky=1 and loss_count=1.
REQ-033 Assert reset in RELEASE after channel 0 is released -> chan_reset returns to all ones with no clock edge, and ready stays 0.
REQ-034 NUM_CHANNELS=4, STAGGER_CYCLES=1, LOCK_STABLE_CYCLES=2 -> chan_reset steps through 1110, 1100, 1000, 0000 on consecutive cycles, and ready rises one cycle after 0000.
